output_buffer: RTL and testbench

OUTPUT_BUFFER -- requirements
Module: output_buffer

---
 rtl/output_buffer.sv | 152 +++++++++++++++
 tb/tb_output_buffer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/output_buffer.sv
// Result FIFO between the compute engine and the AXI write master. Words are
// buffered, then drained in bursts of up to BURST_LENGTH words per request.
module output_buffer #(
  parameter int DATA_WIDTH      = 512,
  parameter int FIFO_ADDR_WIDTH = 7,
  parameter int BURST_LENGTH    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_v,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tvalid,
  input  logic                  tready,
  input  logic [63:0]           addr_base,
  input  logic [31:0]           output_byte,
  input  logic                  op_start,
  input  logic                  end_conv,
  output logic                  wmst_req,
  input  logic                  wmst_done,
  output logic [63:0]           addr_offset,
  output logic [63:0]           xfer_size,
  output logic                  op_done,
  output logic                  busy
);

  localparam int DEPTH             = 1 << FIFO_ADDR_WIDTH;
  localparam int WORD_BYTES        = DATA_WIDTH / 8;
  localparam int BURST_LENGTH_BYTE = BURST_LENGTH * WORD_BYTES;
  localparam logic [31:0] WORD_BYTES_32  = 32'(WORD_BYTES);
  localparam logic [31:0] BURST_BYTES_32 = 32'(BURST_LENGTH_BYTE);
  localparam logic [63:0] BURST_BYTES_64 = 64'(BURST_LENGTH_BYTE);
  localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_CNT = (FIFO_ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, WAIT_DATA, REQ, XFER, WAIT_DONE, FINISH} state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0]      mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]   count;
  logic                       push, pop, empty;

  logic [63:0] base;
  logic [31:0] remaining, remaining_next;
  logic [31:0] burst_idx;
  logic [31:0] burst_words, burst_words_q;
  logic [31:0] sent;
  logic        data_ready, last_pop;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  // end_conv flushes the FIFO, so nothing may enter or leave in that cycle
  assign push  = i_data_v & ~full & busy & ~end_conv;
  assign pop   = tvalid & tready;
  assign tdata = mem[rd_ptr];

  assign burst_words    = ((remaining < BURST_BYTES_32) ? remaining : BURST_BYTES_32) / WORD_BYTES_32;
  assign data_ready     = (32'(count) >= burst_words);
  assign last_pop       = pop & ((sent + 32'd1) == burst_words_q);
  assign remaining_next = remaining - xfer_size[31:0];

  assign busy     = (state != IDLE);
  assign wmst_req = (state == REQ) & ~end_conv;
  assign op_done  = (state == FINISH) & ~end_conv;
  assign tvalid   = (state == XFER) & ~empty & (sent < burst_words_q) & ~end_conv;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || end_conv) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (end_conv) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:      if (op_start) state_next = (output_byte == '0) ? FINISH : WAIT_DATA;
        WAIT_DATA: if (data_ready) state_next = REQ;
        REQ:       state_next = XFER;
        XFER:      if (last_pop) state_next = WAIT_DONE;
        WAIT_DONE: if (wmst_done) state_next = (remaining_next == '0) ? FINISH : WAIT_DATA;
        FINISH:    state_next = IDLE;
        default:   state_next = IDLE;
      endcase
    end
  end

  // Burst bookkeeping; addr_offset/xfer_size are loaded on entry to REQ and held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base          <= '0;
      remaining     <= '0;
      burst_idx     <= '0;
      burst_words_q <= '0;
      sent          <= '0;
      addr_offset   <= '0;
      xfer_size     <= '0;
    end else if (!end_conv) begin
      case (state)
        IDLE: begin
          if (op_start) begin
            base      <= addr_base;
            remaining <= output_byte;
            burst_idx <= '0;
          end
        end
        WAIT_DATA: begin
          if (data_ready) begin
            addr_offset   <= base + (64'(burst_idx) * BURST_BYTES_64);
            xfer_size     <= 64'(burst_words * WORD_BYTES_32);
            burst_words_q <= burst_words;
            sent          <= '0;
          end
        end
        XFER: begin
          if (pop) sent <= sent + 32'd1;
        end
        WAIT_DONE: begin
          if (wmst_done) begin
            remaining <= remaining_next;
            burst_idx <= burst_idx + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_output_buffer.sv
// Directed bench for output_buffer: acts as engine and write master, checks
// burst addresses/sizes, data order, full behaviour, abort and reset.
module tb_output_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] i_data;
  logic         i_data_v;
  logic         full;
  logic [511:0] tdata;
  logic         tvalid;
  logic         tready;
  logic [63:0]  addr_base;
  logic [31:0]  output_byte;
  logic         op_start;
  logic         end_conv;
  logic         wmst_req;
  logic         wmst_done;
  logic [63:0]  addr_offset;
  logic [63:0]  xfer_size;
  logic         op_done;
  logic         busy;

  int tests  = 0;
  int errors = 0;
  int tag_base = 0;

  always #5 clk = ~clk;

  output_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .i_data(i_data), .i_data_v(i_data_v), .full(full),
    .tdata(tdata), .tvalid(tvalid), .tready(tready),
    .addr_base(addr_base), .output_byte(output_byte),
    .op_start(op_start), .end_conv(end_conv),
    .wmst_req(wmst_req), .wmst_done(wmst_done),
    .addr_offset(addr_offset), .xfer_size(xfer_size),
    .op_done(op_done), .busy(busy)
  );

  function automatic logic [511:0] word(input int t);
    word = {16{32'(t)}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_data = '0; i_data_v = 1'b0; tready = 1'b0; op_start = 1'b0;
    end_conv = 1'b0; wmst_done = 1'b0;
  endtask

  // mode: 0 streaming, 1 prefill with tready low then try a push at full,
  // 2 tready toggling plus a stray wmst_done and op_start mid-operation.
  // abort_kind: 0 none, 1 end_conv, 2 reset, after abort_at pops.
  task automatic run_op(input logic [63:0] base, input logic [31:0] bytes,
                        input int mode, input int abort_kind, input int abort_at);
    int words, pushed, popped, reqs, dones, burst_left, opdones, exp_reqs;
    logic [31:0] rem, exp_size;
    logic pend_done, finished, extra_used, early_used, stray_used, aborted;
    words = int'(bytes / 64);
    exp_reqs = int'((bytes + 4095) / 4096);
    pushed = 0; popped = 0; reqs = 0; dones = 0; burst_left = 0; opdones = 0;
    pend_done = 0; finished = 0; extra_used = 0; early_used = 0; stray_used = 0; aborted = 0;
    rem = bytes;
    addr_base = base; output_byte = bytes; op_start = 1'b1;
    step();
    op_start = 1'b0;
    addr_base = 64'hdead_beef_0000_0000;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      op_start  = 1'b0;
      wmst_done = pend_done;
      if (pend_done) dones++;
      pend_done = 0;
      i_data_v = (pushed < words);
      i_data   = word(tag_base + pushed);
      if (mode == 2)      tready = cyc[0];
      else if (mode == 1) tready = (pushed >= words);
      else                tready = 1'b1;
      if (mode == 1 && pushed == words && !extra_used) begin
        tests++;
        if (full !== 1'b1) begin errors++; $display("FAIL full_at_depth: got %b expected 1", full); end
        i_data_v = 1'b1; i_data = '1; tready = 1'b1; extra_used = 1;
      end
      if (mode == 2 && !early_used && reqs > 0 && burst_left == 3) begin
        wmst_done = 1'b1; early_used = 1;
      end
      if (mode == 2 && !stray_used && reqs == 1) begin
        op_start = 1'b1; addr_base = 64'h0; output_byte = 32'd64; stray_used = 1;
      end
      #1;
      if (wmst_req) begin
        exp_size = (rem < 32'd4096) ? rem : 32'd4096;
        tests++;
        if (addr_offset !== base + 64'(reqs) * 64'd4096) begin
          errors++; $display("FAIL addr_offset: got %h expected %h", addr_offset, base + 64'(reqs) * 64'd4096);
        end
        tests++;
        if (xfer_size !== 64'(exp_size)) begin
          errors++; $display("FAIL xfer_size: got %0d expected %0d", xfer_size, exp_size);
        end
        burst_left = int'(exp_size / 64); rem = rem - exp_size; reqs++;
      end
      if (tvalid) begin
        tests++;
        if (burst_left <= 0) begin errors++; $display("FAIL extra_tvalid: got 1 expected 0 (pop %0d)", popped); end
      end
      if (tvalid && tready) begin
        tests++;
        if (tdata !== word(tag_base + popped)) begin
          errors++; $display("FAIL data_order: got %h expected %h", tdata[31:0], 32'(tag_base + popped));
        end
        popped++; burst_left--;
        if (burst_left == 0) pend_done = 1;
      end
      if (i_data_v && !full && pushed < words) pushed++;
      if (op_done) begin
        opdones++; finished = 1;
        tests++;
        if (dones != exp_reqs) begin errors++; $display("FAIL op_done_early: got %0d dones expected %0d", dones, exp_reqs); end
      end
      if (wmst_done && dones > 0) pend_done = pend_done;
      step();
      if (abort_kind != 0 && popped == abort_at) begin aborted = 1; break; end
    end
    wmst_done = 1'b0; op_start = 1'b0;
    if (aborted) begin
      i_data_v = 1'b0; tready = 1'b0;
      if (abort_kind == 1) end_conv = 1'b1; else rst_n = 1'b0;
      step();
      end_conv = 1'b0; rst_n = 1'b1;
      tests++;
      if ({tvalid, wmst_req, op_done, busy, full} !== 5'b0) begin
        errors++; $display("FAIL abort_outputs: got %b expected 00000", {tvalid, wmst_req, op_done, busy, full});
      end
      if (abort_kind == 2) begin
        tests++;
        if ({addr_offset, xfer_size} !== 128'b0) begin
          errors++; $display("FAIL reset_regs: got %h/%h expected 0/0", addr_offset, xfer_size);
        end
      end
      for (int k = 0; k < 5; k++) begin
        tests++;
        if (op_done !== 1'b0 || tvalid !== 1'b0) begin
          errors++; $display("FAIL abort_quiet: got op_done=%b tvalid=%b expected 0", op_done, tvalid);
        end
        step();
      end
    end else begin
      tests++;
      if (!finished) begin errors++; $display("FAIL op_timeout: got no op_done expected op_done"); end
      tests++;
      if (reqs != exp_reqs) begin errors++; $display("FAIL req_count: got %0d expected %0d", reqs, exp_reqs); end
      tests++;
      if (popped != words) begin errors++; $display("FAIL pop_count: got %0d expected %0d", popped, words); end
      tests++;
      if (opdones != 1) begin errors++; $display("FAIL op_done_count: got %0d expected 1", opdones); end
      tests++;
      if (busy !== 1'b0 || op_done !== 1'b0) begin
        errors++; $display("FAIL return_idle: got busy=%b op_done=%b expected 0", busy, op_done);
      end
    end
    idle_inputs();
    tag_base += 1000;
  endtask

  task automatic test_reset();
    idle_inputs();
    addr_base = '0; output_byte = '0;
    rst_n = 1'b0;
    step(); step();
    tests++;
    if ({busy, tvalid, wmst_req, op_done, full} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, tvalid, wmst_req, op_done, full});
    end
    tests++;
    if (addr_offset !== 64'h0 || xfer_size !== 64'h0) begin
      errors++; $display("FAIL reset_regs: got %h/%h expected 0/0", addr_offset, xfer_size);
    end
    rst_n = 1'b1;
    // words offered while idle must be dropped
    i_data_v = 1'b1; i_data = '1;
    step(); step();
    i_data_v = 1'b0;
  endtask

  task automatic test_two_bursts();
    run_op(64'h1000, 32'd8192, 0, 0, 0);
  endtask

  task automatic test_partial_burst();
    run_op(64'h0000_4000_0000_0000, 32'd4160, 0, 0, 0);
  endtask

  task automatic test_full();
    run_op(64'h8000, 32'd8192, 1, 0, 0);
  endtask

  task automatic test_end_conv();
    run_op(64'h10000, 32'd8192, 0, 1, 10);
    run_op(64'h20000, 32'd4096, 0, 0, 0);
  endtask

  task automatic test_toggle_ready();
    run_op(64'h3000, 32'd8192, 2, 0, 0);
  endtask

  task automatic test_reset_mid_xfer();
    run_op(64'h40000, 32'd8192, 0, 2, 10);
    addr_base = 64'h5000; output_byte = 32'd0; op_start = 1'b1;
    step();
    op_start = 1'b0;
    tests++;
    if (op_done !== 1'b1 || wmst_req !== 1'b0) begin
      errors++; $display("FAIL zero_bytes: got op_done=%b wmst_req=%b expected 1/0", op_done, wmst_req);
    end
    step();
    tests++;
    if (op_done !== 1'b0 || busy !== 1'b0 || wmst_req !== 1'b0) begin
      errors++; $display("FAIL zero_bytes_end: got op_done=%b busy=%b wmst_req=%b expected 0", op_done, busy, wmst_req);
    end
    run_op(64'h6000, 32'd128, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_two_bursts();
    test_partial_burst();
    test_full();
    test_end_conv();
    test_toggle_ready();
    test_reset_mid_xfer();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
